grant_priority_tracker: RTL and testbench
=========================================

GRANT_PRIORITY_TRACKER -- requirements
Module: grant_priority_tracker

Interface
REQ-001 SHALL have parameter: candidate, default 2, number of requesters, legal range 2..32.
REQ-002 SHALL define IDX_W = $clog2(candidate) as the width of one requester index.
REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: grant_valid  input  1  arbiter grant this cycle is accepted downstream.
REQ-006 SHALL have port: grant_number  input  IDX_W+1  granted index; MSB=1 means no grant (all-ones from the arbiter).
REQ-007 SHALL have port: grant_last  input  1  accepted grant is the final beat of its transfer.
REQ-008 SHALL have port: priority_array  output  IDX_W x candidate (unpacked [0:candidate-1])  requester order; entry 0 has highest priority.
REQ-009 SHALL have port: locked  output  1  a multi-beat transfer holds the arbitration.
REQ-010 SHALL have port: lock_owner  output  IDX_W  requester holding the lock; valid only while locked=1.
REQ-011 SHALL have port: grant_err  output  1  sticky protocol-error flag.

Function
REQ-012 SHALL drive all outputs from registers; the arbiter consumes priority_array combinationally in the same cycle.
REQ-013 SHALL implement FSM with two states: UNLOCKED and LOCKED.
REQ-014 SHALL treat a grant as taken only when grant_valid=1, grant_number MSB=0 and grant_number < candidate.
REQ-015 SHALL, in UNLOCKED on a taken grant g at array position p, update priority_array one cycle later: entries i<p unchanged; entry i for p<=i<candidate-1 takes old entry i+1; entry candidate-1 takes g (least-recently-granted order).
REQ-016 SHALL, in UNLOCKED on a taken grant with grant_last=0, go to LOCKED with lock_owner=g in the same cycle as the rotation of REQ-015.
REQ-017 SHALL, in UNLOCKED on a taken grant with grant_last=1, stay in UNLOCKED.
REQ-018 SHALL, in LOCKED, freeze priority_array.
REQ-019 SHALL, in LOCKED on a taken grant g==lock_owner with grant_last=1, return to UNLOCKED with the array unchanged.
REQ-020 SHALL, in LOCKED on a taken grant g==lock_owner with grant_last=0, stay in LOCKED with no change.
REQ-021 SHALL, in LOCKED on a taken grant g!=lock_owner, set grant_err, with no change to state or array.
REQ-022 SHALL, on grant_valid=1 with MSB=1, make no change and no error; this is legal in either state.
REQ-023 SHALL, on grant_valid=1 with MSB=0 and grant_number>=candidate, set grant_err with no other change (reachable only for non-power-of-2 candidate).
REQ-024 SHALL ignore grant_number and grant_last when grant_valid=0.
REQ-025 SHALL keep priority_array a permutation of 0..candidate-1 at all times.
REQ-026 SHALL clear grant_err only by reset.

Reset
REQ-027 SHALL, while rst=1 at a clk edge, set priority_array[i]=i, locked=0, lock_owner=0, grant_err=0 and state UNLOCKED.
REQ-028 SHALL give rst priority over any simultaneous grant; a reset during LOCKED drops the lock without a grant_last.

Structure
REQ-029 SHALL place the FSM state enum (UNLOCKED/LOCKED) in shared package xbar_arb_pkg.
REQ-030 SHALL place a rotate-to-tail function (array, position) -> array in xbar_arb_pkg, for reuse by the grant arbiter models.
REQ-031 SHALL contain no sub-module; the position search and rotation are combinational logic inside this module.

Verification (candidate=4 unless stated)
REQ-032 SHALL check: reset -> array [0,1,2,3], locked=0, grant_err=0.
REQ-033 SHALL check: valid, grant=2, last=1 -> next cycle [0,1,3,2], locked=0.
REQ-034 SHALL check: from reset, valid, grant=0, last=0 -> [1,2,3,0], locked=1, owner=0; then valid, grant=0, last=1 -> locked=0, array unchanged.
REQ-035 SHALL check: locked with owner=1, valid, grant=3 -> grant_err=1, array unchanged, locked stays 1.
REQ-036 SHALL check: valid, grant_number=3'b100 -> no change, grant_err=0; with candidate=3, valid, grant_number=2'b11 -> grant_err=1.
REQ-037 SHALL check: rst asserted while locked with a simultaneous valid grant -> next cycle reset state of REQ-027.

Source files
------------

// File: rtl/xbar_arb_pkg.sv
// xbar_arb_pkg: shared arbitration FSM states, sizing limits and the rotate-to-tail helper
package xbar_arb_pkg;
  localparam int MAX_CAND = 32;
  localparam int IDX_MAX = 5;
  typedef enum logic {UNLOCKED, LOCKED} arb_state_t;
  typedef logic [MAX_CAND-1:0][IDX_MAX-1:0] prio_vec_t;
  function automatic prio_vec_t rotate_to_tail(prio_vec_t a, int pos, int n = MAX_CAND);
    prio_vec_t r;
    logic [IDX_MAX-1:0] moved;
    r = a;
    moved = a[0];
    for (int i = 0; i < MAX_CAND; i++) if (i == pos) moved = a[i];
    for (int i = 0; i < MAX_CAND - 1; i++) if (i >= pos && i < n - 1) r[i] = a[i+1];
    for (int i = 0; i < MAX_CAND; i++) if (i == n - 1) r[i] = moved;
    return r;
  endfunction
endpackage

// File: rtl/grant_priority_tracker.sv
// grant_priority_tracker: LRG priority order with multi-beat lock; ports clk, rst, grant_valid/number/last in, priority_array, locked, lock_owner, grant_err out
module grant_priority_tracker
  import xbar_arb_pkg::*;
#(
  parameter int candidate = 2,
  localparam int IDX_W = $clog2(candidate)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_valid,
  input  logic [IDX_W:0]   grant_number,
  input  logic             grant_last,
  output logic [IDX_W-1:0] priority_array [0:candidate-1],
  output logic             locked,
  output logic [IDX_W-1:0] lock_owner,
  output logic             grant_err
);
  arb_state_t state;
  logic [IDX_W-1:0] g;
  logic in_range, taken, bad;
  logic [IDX_W-1:0] pos;
  prio_vec_t cur, rot;
  logic unused_rot;
  assign g = grant_number[IDX_W-1:0];
  assign in_range = {1'b0, g} < (IDX_W+1)'(candidate);
  assign taken = grant_valid && !grant_number[IDX_W] && in_range;
  assign bad = grant_valid && !grant_number[IDX_W] && !in_range;
  always_comb begin
    pos = '0;
    cur = '0;
    for (int i = 0; i < candidate; i++) begin
      cur[i] = IDX_MAX'(priority_array[i]);
      pos = (priority_array[i] == g) ? IDX_W'(i) : pos;
    end
  end
  assign rot = rotate_to_tail(cur, int'(pos), candidate);
  assign unused_rot = ^rot;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= UNLOCKED;
      locked <= 1'b0;
      lock_owner <= '0;
      grant_err <= 1'b0;
      for (int i = 0; i < candidate; i++) priority_array[i] <= IDX_W'(i);
    end else begin
      if (bad) grant_err <= 1'b1;
      if (taken) begin
        if (state == UNLOCKED) begin
          for (int i = 0; i < candidate; i++) priority_array[i] <= rot[i][IDX_W-1:0];
          if (!grant_last) begin
            state <= LOCKED;
            locked <= 1'b1;
            lock_owner <= g;
          end
        end else if (g != lock_owner) begin
          grant_err <= 1'b1;
        end else if (grant_last) begin
          state <= UNLOCKED;
          locked <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_grant_priority_tracker.sv
// tb_grant_priority_tracker: directed checks of priority rotation, locking and error flagging
module tb_grant_priority_tracker;
  logic clk = 0;
  logic rst = 1;
  logic gv4 = 0, gl4 = 0;
  logic [2:0] gn4 = 0;
  logic [1:0] pa4 [0:3];
  logic lk4, err4;
  logic [1:0] own4;
  logic gv3 = 0, gl3 = 0;
  logic [2:0] gn3 = 0;
  logic [1:0] pa3 [0:2];
  logic lk3, err3;
  logic [1:0] own3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  grant_priority_tracker #(.candidate(4)) dut4 (
    .clk(clk), .rst(rst), .grant_valid(gv4), .grant_number(gn4), .grant_last(gl4),
    .priority_array(pa4), .locked(lk4), .lock_owner(own4), .grant_err(err4));

  grant_priority_tracker #(.candidate(3)) dut3 (
    .clk(clk), .rst(rst), .grant_valid(gv3), .grant_number(gn3), .grant_last(gl3),
    .priority_array(pa3), .locked(lk3), .lock_owner(own3), .grant_err(err3));

  function automatic logic [7:0] arr4();
    return {pa4[0], pa4[1], pa4[2], pa4[3]};
  endfunction

  function automatic logic [5:0] arr3();
    return {pa3[0], pa3[1], pa3[2]};
  endfunction

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic drive4(input logic v, input logic [2:0] n, input logic l);
    gv4 = v; gn4 = n; gl4 = l;
    @(posedge clk);
    #1 gv4 = 0; gn4 = 3'b111; gl4 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (arr4() !== 8'b00_01_10_11) begin errors++; $display("FAIL reset_array got %h want %h", arr4(), 8'b00_01_10_11); end
    checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", lk4); end
    checks++; if (own4 !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", own4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err4); end
  endtask

  task automatic test_rotate();
    do_reset();
    drive4(1, 3'd2, 1);
    checks++; if (arr4() !== 8'b00_01_11_10) begin errors++; $display("FAIL rot_g2 got %h want %h", arr4(), 8'b00_01_11_10); end
    checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL rot_g2_locked got %b want 0", lk4); end
    drive4(1, 3'd0, 1);
    checks++; if (arr4() !== 8'b01_11_10_00) begin errors++; $display("FAIL rot_g0 got %h want %h", arr4(), 8'b01_11_10_00); end
    drive4(0, 3'd3, 0);
    checks++; if (arr4() !== 8'b01_11_10_00 || lk4 !== 1'b0) begin errors++; $display("FAIL idle_ignored got %h/%b want %h/0", arr4(), lk4, 8'b01_11_10_00); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive4(1, 3'd3, 1);
    drive4(1, 3'd1, 1);
    checks++; if (arr4() !== 8'b00_10_11_01) begin errors++; $display("FAIL b2b got %h want %h", arr4(), 8'b00_10_11_01); end
  endtask

  task automatic test_lock();
    do_reset();
    drive4(1, 3'd0, 0);
    checks++; if (arr4() !== 8'b01_10_11_00) begin errors++; $display("FAIL lock_array got %h want %h", arr4(), 8'b01_10_11_00); end
    checks++; if (lk4 !== 1'b1 || own4 !== 2'd0) begin errors++; $display("FAIL lock_state got %b/%0d want 1/0", lk4, own4); end
    drive4(1, 3'd0, 0);
    checks++; if (arr4() !== 8'b01_10_11_00 || lk4 !== 1'b1) begin errors++; $display("FAIL lock_midbeat got %h/%b want %h/1", arr4(), lk4, 8'b01_10_11_00); end
    drive4(1, 3'd0, 1);
    checks++; if (lk4 !== 1'b0) begin errors++; $display("FAIL unlock got %b want 0", lk4); end
    checks++; if (arr4() !== 8'b01_10_11_00 || err4 !== 1'b0) begin errors++; $display("FAIL unlock_array got %h/%b want %h/0", arr4(), err4, 8'b01_10_11_00); end
  endtask

  task automatic test_lock_err();
    do_reset();
    drive4(1, 3'd1, 0);
    checks++; if (arr4() !== 8'b00_10_11_01 || own4 !== 2'd1) begin errors++; $display("FAIL lock1 got %h/%0d want %h/1", arr4(), own4, 8'b00_10_11_01); end
    drive4(1, 3'd3, 1);
    checks++; if (err4 !== 1'b1) begin errors++; $display("FAIL wrong_owner_err got %b want 1", err4); end
    checks++; if (arr4() !== 8'b00_10_11_01 || lk4 !== 1'b1) begin errors++; $display("FAIL wrong_owner_state got %h/%b want %h/1", arr4(), lk4, 8'b00_10_11_01); end
    drive4(1, 3'd4, 1);
    checks++; if (lk4 !== 1'b1 || arr4() !== 8'b00_10_11_01) begin errors++; $display("FAIL nogrant_locked got %b/%h want 1/%h", lk4, arr4(), 8'b00_10_11_01); end
    drive4(1, 3'd1, 1);
    checks++; if (lk4 !== 1'b0 || err4 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b/%b want 0/1", lk4, err4); end
  endtask

  task automatic test_no_grant();
    do_reset();
    drive4(1, 3'b100, 0);
    checks++; if (arr4() !== 8'b00_01_10_11 || lk4 !== 1'b0) begin errors++; $display("FAIL msb_nochange got %h/%b want %h/0", arr4(), lk4, 8'b00_01_10_11); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL msb_noerr got %b want 0", err4); end
    gv3 = 1; gn3 = 3'b011; gl3 = 0;
    @(posedge clk);
    #1 gv3 = 0;
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", err3); end
    checks++; if (arr3() !== 6'b00_01_10 || lk3 !== 1'b0) begin errors++; $display("FAIL range_nochange got %h/%b want %h/0", arr3(), lk3, 6'b00_01_10); end
    gv3 = 1; gn3 = 3'd0; gl3 = 1;
    @(posedge clk);
    #1 gv3 = 0;
    checks++; if (arr3() !== 6'b01_10_00 || err3 !== 1'b1) begin errors++; $display("FAIL c3_rotate got %h/%b want %h/1", arr3(), err3, 6'b01_10_00); end
  endtask

  task automatic test_reset_locked();
    do_reset();
    drive4(1, 3'd2, 0);
    checks++; if (lk4 !== 1'b1 || own4 !== 2'd2) begin errors++; $display("FAIL prelock got %b/%0d want 1/2", lk4, own4); end
    rst = 1; gv4 = 1; gn4 = 3'd2; gl4 = 0;
    @(posedge clk);
    #1 rst = 0; gv4 = 0;
    checks++; if (arr4() !== 8'b00_01_10_11 || lk4 !== 1'b0) begin errors++; $display("FAIL rst_locked got %h/%b want %h/0", arr4(), lk4, 8'b00_01_10_11); end
    checks++; if (own4 !== 2'd0 || err4 !== 1'b0) begin errors++; $display("FAIL rst_locked_owner got %0d/%b want 0/0", own4, err4); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_back_to_back();
    test_lock();
    test_lock_err();
    test_no_grant();
    test_reset_locked();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
